// File: rtl/fifo_stream_pkg.sv
// Shared defaults and types for the FIFO stream reader and its output buffer.
package fifo_stream_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned BufDepth = 2;

  typedef logic [DefDataW-1:0] word_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO; the head entry is always visible on head_o.
module skid_buf2 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en_i & (count_q != 2'd0);
    do_wr    = wr_en_i & (count_q != 2'd2);
    // Next free slot sits one past the head when exactly one entry is held.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    count_d  = count_q + {1'b0, do_wr} - {1'b0, do_rd};
    rd_ptr_d = rd_ptr_q ^ do_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr] <= wr_data_i;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream with a 2-word buffer.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  word_count_o,
  output logic              busy_o
);

  logic             inflight_q;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       buf_count;
  logic             pop_now;
  logic [2:0]       occ, occ_after;

  skid_buf2 #(
    .Width (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (inflight_q),
    .wr_data_i (fifo_rd_data_i),
    .rd_en_i   (pop_now),
    .head_o    (out_data_o),
    .count_o   (buf_count)
  );

  always_comb begin
    out_valid_o = (buf_count != 2'd0);
    pop_now     = out_valid_o & out_ready_i;
    occ         = {1'b0, buf_count} + {2'b0, inflight_q};
    occ_after   = occ - {2'b0, pop_now};
    // Credit check counts the in-flight word so the buffer can never be overrun.
    fifo_rd_en_o = rst_n & enable_i & ~fifo_empty_i & (occ_after < 3'(BufDepth));
    busy_o       = inflight_q | out_valid_o;
    word_cnt_d   = word_cnt_q + CNT_W'(pop_now);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en_o;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_count_o = word_cnt_q;

  buf_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && (buf_count == 2'd2)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a word-accounting model.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int unsigned CntW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic gap = 1'b0;
  logic out_ready = 1'b0;
  logic fifo_empty, fifo_rd_en, out_valid, busy;
  word_t fifo_rd_data = '0;
  word_t out_data;
  logic [CntW-1:0] word_count;

  word_t fifo_mem [256];
  int push_cnt = 0;
  int pop_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: words popped and words delivered since the last reset.
  int    pops_sr = 0;
  int    xfers_sr = 0;
  int    exp_idx = 0;
  int    m_occ;
  logic  m_pop;
  logic  last_pop = 1'b0;
  logic  prev_stall = 1'b0;
  word_t prev_data = '0;

  fifo_stream_reader #(
    .DATA_W (32),
    .CNT_W  (CntW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .word_count_o   (word_count),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (push_cnt == pop_cnt) || gap;

  // Source FIFO with one-cycle read latency.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[pop_cnt[7:0]];
      pop_cnt      <= pop_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_rd_en", fifo_rd_en, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_count", word_count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_data", out_data, 0);
      pops_sr    = 0;
      xfers_sr   = 0;
      last_pop   = 1'b0;
      prev_stall = 1'b0;
      exp_idx    = pop_cnt;
    end else begin
      m_occ = pops_sr - xfers_sr;
      m_pop = out_valid & out_ready;
      check_eq("occ_le_2", m_occ <= 2, 1);
      check_eq("out_valid", out_valid, (m_occ - int'(last_pop)) > 0);
      check_eq("busy", busy, m_occ > 0);
      check_eq("word_count", word_count, xfers_sr % (1 << CntW));
      check_eq("rd_en", fifo_rd_en,
               enable & ~fifo_empty & ((m_occ - int'(m_pop)) < 2));
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, prev_data);
      end
      if (m_pop) begin
        check_eq("data", out_data, fifo_mem[exp_idx[7:0]]);
        exp_idx++;
        xfers_sr++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      last_pop   = fifo_rd_en;
      if (fifo_rd_en) pops_sr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input word_t w);
    fifo_mem[push_cnt[7:0]] = w;
    push_cnt++;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while ((busy || (push_cnt != pop_cnt)) && i < 200) begin
      tick(1);
      i++;
    end
    check_eq(tag, i < 200, 1);
  endtask

  initial begin
    int s;
    int i;
    // Reset held with a non-empty FIFO and enable high.
    rst_n     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) push(word_t'(k));
    tick(3);
    enable = 1'b0;
    rst_n  = 1'b1;
    tick(1);

    // Streaming 1..8: two-cycle fill, then one word per clock.
    enable = 1'b1;
    #1;
    check_eq("fill_rd_en", fifo_rd_en, 1);
    check_eq("fill_valid0", out_valid, 0);
    tick(1);
    check_eq("fill_valid1", out_valid, 0);
    tick(1);
    check_eq("fill_valid2", out_valid, 1);
    check_eq("fill_data", out_data, 1);
    tick(8);
    check_eq("stream_count", word_count, 8);
    check_eq("stream_busy", busy, 0);

    // Backpressure mid-stream.
    for (int k = 0; k < 20; k++) push(word_t'($urandom));
    tick(3);
    out_ready = 1'b0;
    s = pop_cnt;
    tick(5);
    check_eq("bp_pops", (pop_cnt - s) <= 2, 1);
    check_eq("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle("bp_drain");

    // Random traffic with FIFO gaps, stalls and enable drops.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(2, 0) == 0) push(word_t'($urandom));
      out_ready = ($urandom_range(3, 0) != 0);
      gap       = ($urandom_range(4, 0) == 0);
      enable    = ($urandom_range(7, 0) != 0);
      tick(1);
    end
    enable    = 1'b1;
    gap       = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_drain");

    // Drop enable right after a pop: that word still lands, nothing more is read.
    for (int k = 0; k < 6; k++) push(word_t'($urandom));
    i = 0;
    while (!fifo_rd_en && i < 20) begin
      tick(1);
      i++;
    end
    check_eq("en_seen_rd", fifo_rd_en, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    s = pop_cnt;
    tick(6);
    check_eq("en_no_pop", pop_cnt, s);
    check_eq("en_busy", busy, 0);
    check_eq("en_delivered", exp_idx, pop_cnt);

    // Fill the buffer to two words, then reset asynchronously mid-cycle.
    enable    = 1'b1;
    out_ready = 1'b0;
    tick(4);
    check_eq("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", out_valid, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_data", out_data, 0);
    check_eq("async_rd_en", fifo_rd_en, 0);
    tick(2);
    // Exactly 17 words available after restart exercises the 4-bit wrap.
    s = 17 - (push_cnt - pop_cnt);
    for (int k = 0; k < s; k++) push(word_t'($urandom));
    out_ready = 1'b1;
    rst_n     = 1'b1;
    wait_idle("wrap_drain");
    check_eq("wrap_count", word_count, 1);
    check_eq("wrap_all", exp_idx, push_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
